// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame transmitter: FSM states,
// default bit timing in clk cycles and the GRB pixel layout.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_LATCH
  } ws_state_e;

  localparam int T0H_DEF  = 20;
  localparam int T1H_DEF  = 40;
  localparam int TBIT_DEF = 63;
  localparam int TRST_DEF = 2600;

  localparam int PIX_W = 24;
  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;

  localparam int CNT_W     = 16;
  localparam int PIX_IDX_W = 11;
  localparam int BIT_IDX_W = 5;

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel buffer: one synchronous write port and one
// registered read port. A same-address read/write returns the old word.
module ws2812_pixel_ram
  import ws2812_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame transmitter: streams n pixels from the pixel buffer MSB first
// as fixed-period high/low bit cells, then holds the line low to latch.
module ws2812_frame_tx
  import ws2812_pkg::*;
#(
  parameter int T0H      = T0H_DEF,
  parameter int T1H      = T1H_DEF,
  parameter int TBIT     = TBIT_DEF,
  parameter int TRST     = TRST_DEF,
  parameter int MAX_LEDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic [23:0] rgb_data,
  input  logic [9:0]  address,
  input  logic [15:0] led_count,
  input  logic        start,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int AW = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1;

  localparam logic [CNT_W-1:0] T0H_LAST  = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T1H_LAST  = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] TBIT_LAST = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] TBIT_PRE  = CNT_W'(TBIT - 2);
  localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(TRST - 1);

  ws_state_e              state;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [PIX_IDX_W-1:0]   pix_idx;
  logic [PIX_IDX_W-1:0]   n_leds;
  logic [PIX_W-1:0]       shift_reg;
  logic [PIX_W-1:0]       rd_data;

  logic                   ram_we;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic                   start_ok;
  logic                   last_bit;
  logic                   more_pix;
  logic                   hi_done;
  logic                   bit_done;
  logic                   latch_done;

  assign start_ok   = (state == ST_IDLE) && start && (led_count != 16'd0);
  assign last_bit   = (bit_idx == BIT_IDX_W'(23));
  assign more_pix   = (pix_idx < (n_leds - PIX_IDX_W'(1)));
  assign hi_done    = (cnt == (shift_reg[PIX_W-1] ? T1H_LAST : T0H_LAST));
  assign bit_done   = (cnt == TBIT_LAST);
  assign latch_done = (cnt == TRST_LAST);

  // The next pixel is fetched one cycle early so its first bit follows
  // the previous pixel's last bit without a gap.
  assign rd_en   = start_ok ||
                   ((state == ST_BIT_LO) && last_bit && more_pix && (cnt == TBIT_PRE));
  assign rd_addr = (state == ST_IDLE) ? '0 : AW'(pix_idx + PIX_IDX_W'(1));
  assign ram_we  = write && ({22'd0, address} < 32'(MAX_LEDS));

  ws2812_pixel_ram #(
    .DEPTH (MAX_LEDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (address[AW-1:0]),
    .wdata (rgb_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      pix_idx    <= '0;
      n_leds     <= '0;
      shift_reg  <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            n_leds  <= (led_count > 16'(MAX_LEDS)) ? PIX_IDX_W'(MAX_LEDS)
                                                   : led_count[PIX_IDX_W-1:0];
            pix_idx <= '0;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_reg <= rd_data;
          bit_idx   <= '0;
          cnt       <= '0;
          dout      <= 1'b1;
          state     <= ST_BIT_HI;
        end
        ST_BIT_HI: begin
          cnt <= cnt + CNT_W'(1);
          if (hi_done) begin
            dout  <= 1'b0;
            state <= ST_BIT_LO;
          end
        end
        ST_BIT_LO: begin
          if (bit_done) begin
            cnt <= '0;
            if (!last_bit) begin
              shift_reg <= {shift_reg[PIX_W-2:0], 1'b0};
              bit_idx   <= bit_idx + BIT_IDX_W'(1);
              dout      <= 1'b1;
              state     <= ST_BIT_HI;
            end else if (more_pix) begin
              shift_reg <= rd_data;
              bit_idx   <= '0;
              pix_idx   <= pix_idx + PIX_IDX_W'(1);
              dout      <= 1'b1;
              state     <= ST_BIT_HI;
            end else begin
              state <= ST_LATCH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LATCH: begin
          if (latch_done) begin
            cnt        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
